// File: rtl/counter_io_latch.sv
// Purpose: per-counter 8254 bus stage - control word decode, count register writes, output latch and reads.
// Latency: cr_load/cr_value and data_out/data_oe appear one clk after the wr/rd strobe cycle.
// Backpressure: none; the CPU bus strobes are single-cycle and always accepted.
module counter_io_latch #(
  parameter int COUNTER_ID = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  enable,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  data_in,
  input  logic [15:0] count_value,
  input  logic        ce_loaded,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [15:0] cr_value,
  output logic        cr_load,
  output logic [2:0]  mode,
  output logic        bcd,
  output logic [1:0]  rw_mode,
  output logic        null_count
);

  localparam logic [1:0] L_SC = 2'(COUNTER_ID);

  logic [7:0]  r_data_out;
  logic        r_data_oe;
  logic [15:0] r_cr_value;
  logic        r_cr_load;
  logic [2:0]  r_mode;
  logic        r_bcd;
  logic [1:0]  r_rw_mode;
  logic        r_null_count;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [15:0] r_ol;
  logic        r_ol_full;

  logic        w_sel;
  logic        w_cw_hit;
  logic        w_latch_cmd;
  logic        w_program;
  logic        w_cnt_wr;
  logic        w_cnt_rd;
  logic [2:0]  w_norm_mode;
  logic [15:0] w_src;
  logic [7:0]  w_rd_byte;
  logic        w_rd_ptr_nxt;
  logic        w_rd_last;
  logic [15:0] w_cr_nxt;
  logic        w_wr_ptr_nxt;
  logic        w_wr_done;

  // Bus decode. Control words aimed at another counter (including read-back, SC=11) never hit.
  assign w_sel       = enable[COUNTER_ID];
  assign w_cw_hit    = enable[3] & wr & (data_in[7:6] == L_SC);
  assign w_latch_cmd = w_cw_hit & (data_in[5:4] == 2'b00);
  assign w_program   = w_cw_hit & (data_in[5:4] != 2'b00);
  assign w_cnt_wr    = w_sel & wr & ~enable[3];
  // A write in the same cycle suppresses any read.
  assign w_cnt_rd    = w_sel & rd & ~wr;
  // Modes 6 and 7 are aliases of 2 and 3.
  assign w_norm_mode = {data_in[3] & ~data_in[2], data_in[2:1]};
  assign w_src       = r_ol_full ? r_ol : count_value;

  // Read byte selection and read-pointer sequencing for the current rw_mode.
  always_comb begin
    w_rd_byte    = 8'h00;
    w_rd_ptr_nxt = r_rd_ptr;
    w_rd_last    = 1'b0;
    case (r_rw_mode)
      2'b01: begin
        w_rd_byte = w_src[7:0];
        w_rd_last = 1'b1;
      end
      2'b10: begin
        w_rd_byte = w_src[15:8];
        w_rd_last = 1'b1;
      end
      2'b11: begin
        if (!r_rd_ptr) begin
          w_rd_byte    = w_src[7:0];
          w_rd_ptr_nxt = 1'b1;
        end else begin
          w_rd_byte    = w_src[15:8];
          w_rd_ptr_nxt = 1'b0;
          w_rd_last    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Count register assembly and write-pointer sequencing for the current rw_mode.
  always_comb begin
    w_cr_nxt     = r_cr_value;
    w_wr_ptr_nxt = r_wr_ptr;
    w_wr_done    = 1'b0;
    case (r_rw_mode)
      2'b01: begin
        w_cr_nxt  = {8'h00, data_in};
        w_wr_done = 1'b1;
      end
      2'b10: begin
        w_cr_nxt  = {data_in, 8'h00};
        w_wr_done = 1'b1;
      end
      2'b11: begin
        if (!r_wr_ptr) begin
          w_cr_nxt[7:0] = data_in;
          w_wr_ptr_nxt  = 1'b1;
        end else begin
          w_cr_nxt[15:8] = data_in;
          w_wr_ptr_nxt   = 1'b0;
          w_wr_done      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // All register state; reset aborts any partial byte sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= 8'h00;
      r_data_oe    <= 1'b0;
      r_cr_value   <= 16'h0000;
      r_cr_load    <= 1'b0;
      r_mode       <= 3'b000;
      r_bcd        <= 1'b0;
      r_rw_mode    <= 2'b00;
      r_null_count <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_ol         <= 16'h0000;
      r_ol_full    <= 1'b0;
    end else begin
      r_cr_load <= 1'b0;
      r_data_oe <= 1'b0;
      // A second latch command while full keeps the first snapshot.
      if (w_latch_cmd && !r_ol_full) begin
        r_ol      <= count_value;
        r_ol_full <= 1'b1;
      end
      if (w_program) begin
        r_rw_mode <= data_in[5:4];
        r_mode    <= w_norm_mode;
        r_bcd     <= data_in[0];
        r_wr_ptr  <= 1'b0;
        r_rd_ptr  <= 1'b0;
        r_ol_full <= 1'b0;
      end
      if (w_cnt_wr) begin
        r_cr_value <= w_cr_nxt;
        r_wr_ptr   <= w_wr_ptr_nxt;
        r_cr_load  <= w_wr_done;
      end
      if (w_cnt_rd) begin
        r_data_out <= w_rd_byte;
        r_data_oe  <= 1'b1;
        r_rd_ptr   <= w_rd_ptr_nxt;
        if (w_rd_last) begin
          r_ol_full <= 1'b0;
        end
      end
      // Setting null_count wins over a coincident ce_loaded.
      if (w_program || (w_cnt_wr && w_wr_done)) begin
        r_null_count <= 1'b1;
      end else if (ce_loaded) begin
        r_null_count <= 1'b0;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_oe    = r_data_oe;
  assign cr_value   = r_cr_value;
  assign cr_load    = r_cr_load;
  assign mode       = r_mode;
  assign bcd        = r_bcd;
  assign rw_mode    = r_rw_mode;
  assign null_count = r_null_count;

endmodule

// File: doc/counter_io_latch.md
Name: counter_io_latch

Overview:
- Per-counter bus interface stage of the 8254, directly downstream of the read/write address decoder.
- Consumes the decoder's one-hot enable plus read/write strobes and the 8-bit data bus.
- Decodes control words addressed to its counter, sequences LSB/MSB byte writes into a 16-bit count register, and handles counter-latch commands and byte-sequenced reads.
- Three instances are used, COUNTER_ID 0..2; each feeds its counting element.

Parameters:
COUNTER_ID, 0, counter index (0..2) matched against control word bits D7:D6.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
enable  input  4  one-hot from decoder: [0..2] counters, [3] control register; 0000 = chip not selected
wr  input  1  write strobe, active-high, exactly one clk wide per bus write
rd  input  1  read strobe, active-high, exactly one clk wide per bus read
data_in  input  8  CPU write data
count_value  input  16  live count from counting element
ce_loaded  input  1  pulse from counting element: count register transferred into element
data_out  output  8  read data, registered
data_oe  output  1  one-cycle valid/drive enable for data_out
cr_value  output  16  assembled count register
cr_load  output  1  one-cycle pulse: new complete count written
mode  output  3  programmed mode, normalized
bcd  output  1  programmed BCD flag
rw_mode  output  2  programmed RW field
null_count  output  1  high from count write until ce_loaded

Behaviour:
- Reset (rst=1 at a clock edge) clears all state: data_out=0, data_oe=0, cr_value=0, cr_load=0, mode=0, bcd=0, rw_mode=00, null_count=0, write pointer=0, read pointer=0, latch empty.
- Reset takes priority over every other input and aborts any partial write or read sequence.
- Sel = enable[COUNTER_ID]. Ctl = enable[3]. Strobes with neither asserted are ignored.
- If wr and rd are asserted in the same cycle, wr is processed and rd is ignored (data_oe stays 0).

Control write (Ctl & wr):
- D7:D6 != COUNTER_ID: no effect. This includes 11 (read-back), which is ignored by this block.
- D5:D4 = 00 (counter latch command): if the latch is empty, OL <= count_value and the latch is marked full. If already full, the command is ignored and the first latched value is kept.
- D5:D4 != 00 (program):
  - rw_mode <= D5:D4.
  - mode <= D3:D1, with 110 -> 010 and 111 -> 011.
  - bcd <= D0.
  - Write and read pointers <= 0; latch cleared; null_count <= 1; cr_value unchanged; no cr_load.

Counter write (Sel & wr):
- rw_mode 00: ignored.
- rw_mode 01: cr_value <= {8'h00, data_in}; cr_load.
- rw_mode 10: cr_value <= {data_in, 8'h00}; cr_load.
- rw_mode 11:
  - Pointer 0: cr_value[7:0] <= data_in; pointer <= 1; no cr_load.
  - Pointer 1: cr_value[15:8] <= data_in; pointer <= 0; cr_load.
- Every cr_load also sets null_count <= 1.
- cr_load and the new cr_value appear on the clock edge ending the wr cycle, i.e. 1-cycle latency. cr_load lasts one cycle.
- null_count clears on ce_loaded. If ce_loaded and a null_count-setting event occur in the same cycle, set wins.

Counter read (Sel & rd & !wr):
- Source = OL if latch full, else count_value at the rd cycle.
- rw_mode 01: low byte.
- rw_mode 10: high byte.
- rw_mode 11: read pointer 0 -> low byte, pointer <= 1; pointer 1 -> high byte, pointer <= 0.
- rw_mode 00: data_out = 00.
- data_out is registered and data_oe=1 for exactly the cycle after the rd cycle; otherwise data_oe=0 and data_out holds its last value.
- The latch releases (becomes empty) after the final byte of the read sequence: after the single byte for rw_mode 01/10, after the MSB for rw_mode 11.
- Read and write pointers are independent.
- Control-register reads (Ctl & rd) are ignored.

Test Plan:
- COUNTER_ID=1; control write 0x74 (SC=01, RW=11, M=010, BCD=0); then writes 0x34, 0x12 -> after the first write cr_load=0 and cr_value[7:0]=0x34; after the second, a single cr_load pulse with cr_value=0x1234; null_count=1 until ce_loaded pulse, then 0.
- Control word 0x1C on COUNTER_ID=0 (RW=01, M=110) -> mode=010, rw_mode=01; write 0xAB -> cr_value=0x00AB with cr_load. Control word 0x5C (SC=01) -> no change to instance 0.
- RW=11; count_value=0xBEEF; latch command 0x40 (SC=01); count_value changes to 0x0001; second latch command ignored; two reads -> data_out 0xEF then 0xBE, data_oe one cycle each. Third read -> live 0x01.
- rw_mode=11; write 0x55 only, then new control word 0x76 -> write pointer reset; writes 0x01, 0x02 -> cr_value=0x0201 with exactly one cr_load.
- Simultaneous wr and rd with Sel -> write is performed, no data_oe. Assert rst mid rw_mode=11 sequence -> all outputs to reset values, later writes ignored until reprogrammed.
